// File: rtl/fifo_rd_pkg.sv
// Shared types and default sizes for the FIFO burst reader slice.
// State encoding plus the skid-buffer depth used by the top and the buffer.
package fifo_rd_pkg;

    localparam int DEF_DATA_SIZE = 8;
    localparam int DEF_LEN_W     = 10;
    localparam int SKID_DEPTH    = 2;
    localparam int OCC_W         = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } rd_state_t;

endpackage

// File: rtl/fifo_burst_reader_if.sv
// Bundles the FIFO read port (rEmpty/rData/rinc) and the downstream valid/ready stream.
// master = the burst reader, slave = the FIFO plus downstream consumer.
interface fifo_burst_reader_if
    import fifo_rd_pkg::*;
#(
    parameter int DATA_SIZE = DEF_DATA_SIZE
);

    logic                 rEmpty;
    logic [DATA_SIZE-1:0] rData;
    logic                 rinc;
    logic                 out_valid;
    logic                 out_ready;
    logic [DATA_SIZE-1:0] out_data;

    modport master (
        input  rEmpty,
        input  rData,
        input  out_ready,
        output rinc,
        output out_valid,
        output out_data
    );

    modport slave (
        output rEmpty,
        output rData,
        output out_ready,
        input  rinc,
        input  out_valid,
        input  out_data
    );

endinterface

// File: rtl/rd_skid_buf.sv
// Two-entry valid/ready skid buffer; head is always the oldest stored word.
// Push into a full buffer or pop from an empty one is ignored.
module rd_skid_buf
    import fifo_rd_pkg::*;
#(
    parameter int DATA_SIZE = DEF_DATA_SIZE
) (
    input  logic                 rclk,
    input  logic                 rrst,
    input  logic                 i_push,
    input  logic [DATA_SIZE-1:0] i_pushData,
    input  logic                 i_pop,
    output logic [OCC_W-1:0]     o_occ,
    output logic [DATA_SIZE-1:0] o_head
);

    logic [DATA_SIZE-1:0] r_mem0;
    logic [DATA_SIZE-1:0] r_mem1;
    logic [OCC_W-1:0]     r_occ;
    logic                 w_push;
    logic                 w_pop;

    assign w_push = i_push && (r_occ != OCC_W'(SKID_DEPTH));
    assign w_pop  = i_pop && (r_occ != '0);

    // Entry 0 is the head; a pop shifts entry 1 forward, a simultaneous push refills behind it.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            r_mem0 <= '0;
            r_mem1 <= '0;
            r_occ  <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_occ == '0) begin
                        r_mem0 <= i_pushData;
                    end else begin
                        r_mem1 <= i_pushData;
                    end
                    r_occ <= r_occ + OCC_W'(1);
                end
                2'b01: begin
                    r_mem0 <= r_mem1;
                    r_occ  <= r_occ - OCC_W'(1);
                end
                2'b11: begin
                    if (r_occ == OCC_W'(1)) begin
                        r_mem0 <= i_pushData;
                    end else begin
                        r_mem0 <= r_mem1;
                        r_mem1 <= i_pushData;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_occ  = r_occ;
    assign o_head = r_mem0;

endmodule

// File: rtl/fifo_burst_reader.sv
// Read-side burst consumer: pops burst_len words from a show-ahead FIFO and streams them out.
// Optional running checksum output enabled by defining BURST_READER_CSUM_EN.
module fifo_burst_reader
    import fifo_rd_pkg::*;
#(
    parameter int DATA_SIZE = DEF_DATA_SIZE,
    parameter int LEN_W     = DEF_LEN_W
) (
    input  logic                 rclk,
    input  logic                 rrst,
    input  logic                 start,
    input  logic [LEN_W-1:0]     burst_len,
    fifo_burst_reader_if.master  bus,
    output logic                 busy,
    output logic                 done,
    output logic [LEN_W-1:0]     rd_count
`ifdef BURST_READER_CSUM_EN
    ,
    output logic [DATA_SIZE-1:0] csum
`endif
);

    rd_state_t            r_state;
    rd_state_t            w_nextState;
    logic [LEN_W-1:0]     r_lenQ;
    logic [LEN_W-1:0]     r_issued;
    logic [LEN_W-1:0]     r_rdCount;
    logic [OCC_W-1:0]     w_occ;
    logic [DATA_SIZE-1:0] w_head;
    logic                 w_accept;
    logic                 w_fire;
    logic                 w_rinc;
    logic                 w_lastFire;

    assign w_accept   = (r_state == IDLE) && start;
    assign w_fire     = (w_occ != '0) && bus.out_ready;
    assign w_lastFire = w_fire && ((r_rdCount + LEN_W'(1)) == r_lenQ);
    // Pop decision uses registered state only so downstream ready never reaches rinc.
    assign w_rinc     = (r_state == RUN) && !bus.rEmpty && (r_issued < r_lenQ)
                        && (w_occ < OCC_W'(SKID_DEPTH));

    rd_skid_buf #(
        .DATA_SIZE (DATA_SIZE)
    ) u_skid (
        .rclk       (rclk),
        .rrst       (rrst),
        .i_push     (w_rinc),
        .i_pushData (bus.rData),
        .i_pop      (w_fire),
        .o_occ      (w_occ),
        .o_head     (w_head)
    );

    always_ff @(posedge rclk) begin
        if (rrst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_nextState = (burst_len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (w_lastFire) begin
                    w_nextState = DONE;
                end
            end
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        bus.rinc      = w_rinc;
        bus.out_valid = (w_occ != '0);
        bus.out_data  = w_head;
        busy          = (r_state != IDLE);
        done          = (r_state == DONE);
    end

    // issued never passes len_q, so neither counter can wrap inside a burst.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            r_lenQ    <= '0;
            r_issued  <= '0;
            r_rdCount <= '0;
        end else if (w_accept) begin
            r_lenQ    <= burst_len;
            r_issued  <= '0;
            r_rdCount <= '0;
        end else begin
            if (w_rinc) begin
                r_issued <= r_issued + LEN_W'(1);
            end
            if (w_fire) begin
                r_rdCount <= r_rdCount + LEN_W'(1);
            end
        end
    end

    assign rd_count = r_rdCount;

`ifdef BURST_READER_CSUM_EN
    logic [DATA_SIZE-1:0] r_csum;

    always_ff @(posedge rclk) begin
        if (rrst) begin
            r_csum <= '0;
        end else if (w_accept) begin
            r_csum <= '0;
        end else if (w_fire) begin
            r_csum <= r_csum + w_head;
        end
    end

    assign csum = r_csum;
`endif

endmodule
